uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, number of tick pulses per bit period; legal values are 8 or 16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low; asserted (0) on a rising clk edge resets the block.
REQ-004 tick  input  1  one-clk-wide enable pulse at OVERSAMPLE x baud rate, from the shared baud generator.
REQ-005 rx  input  1  serial line, asynchronous to clk, idle high; 8N1 framing, LSB first.
REQ-006 data_out  output  8  last correctly framed byte; holds its value until the next good frame.
REQ-007 valid  output  1  one-clk pulse; data_out is new and good.
REQ-008 frame_err  output  1  one-clk pulse; stop bit was sampled low and the byte was discarded.
REQ-009 busy  output  1  high while a frame is being received (START, DATA and STOP states).

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; all logic below uses the synchronized value rx_s.
REQ-011 FSM states SHALL be IDLE, START, DATA and STOP, held in a 2-bit state register.
REQ-012 Counters SHALL be sub_cnt (log2(OVERSAMPLE) bits, counts ticks) and bit_cnt (3 bits, counts data bits); both clear on every state entry.
REQ-013 IDLE: the block arms only after rx_s has been seen at 1; an armed IDLE with rx_s==0 moves to START on the next clk, regardless of tick.
REQ-014 START: sub_cnt increments on tick; on the tick where sub_cnt==OVERSAMPLE/2-1, rx_s==0 moves to DATA, and rx_s==1 treats the start as a glitch and returns to IDLE (still armed, no pulses).
REQ-015 DATA: sub_cnt increments on tick and wraps; on the tick where sub_cnt==OVERSAMPLE-1 (mid-bit), rx_s shifts into the shift register at position bit_cnt, LSB first, and bit_cnt increments.
REQ-016 DATA: on the sample tick with bit_cnt==7, the FSM moves to STOP.
REQ-017 STOP: on the tick where sub_cnt==OVERSAMPLE-1, rx_s==1 loads data_out from the shift register and pulses valid; rx_s==0 pulses frame_err, leaves data_out unchanged and disarms IDLE. The FSM then returns to IDLE.
REQ-018 valid and frame_err SHALL rise on the clk edge that leaves STOP, stay high for exactly one clk, and never be high together.
REQ-019 busy SHALL be registered and high exactly while the state is START, DATA or STOP.
REQ-020 When tick is low, no counter, shift register or state SHALL advance, except the IDLE->START transition.
REQ-021 Latency: valid SHALL assert 1 clk after the stop-bit sample tick, which is 9.5 bit periods plus synchronizer delay after the start-bit falling edge.
REQ-022 A falling edge on rx_s while armed in the same clk that STOP exits SHALL be caught on the next clk in IDLE, so back-to-back frames are not lost.
REQ-023 A line held low (break) SHALL produce exactly one frame_err and no further frames until rx_s returns to 1.

Reset
REQ-024 While rst==0 at a clk edge: state=IDLE; IDLE disarmed; sub_cnt=0, bit_cnt=0; shift register=0x00; data_out=0x00; valid=0, frame_err=0, busy=0; synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no valid or frame_err pulse; the next frame is received normally once rx_s has been seen at 1.

Verification
REQ-026 OVERSAMPLE=16, send 0xA5 with a good stop bit -> one valid pulse, data_out=0xA5, frame_err=0, busy high from START entry to IDLE.
REQ-027 Drive rx low for 4 ticks, then high -> return to IDLE at mid-start check, busy drops, no valid or frame_err pulse.
REQ-028 Send 0x3C with the stop bit low -> one frame_err pulse, no valid pulse, data_out keeps its previous value; hold rx low 3 more bit times -> no further pulses.
REQ-029 Send 0x00 then 0xFF back-to-back with no idle gap -> two valid pulses, data_out 0x00 then 0xFF.
REQ-030 Assert rst during bit 4 of 0x5A, release, then send 0xC3 -> no pulse for 0x5A, data_out=0xC3 with one valid pulse.
REQ-031 Stall tick for 50 clks in the middle of DATA -> state and counters hold; the byte is still received correctly once ticks resume.

Source files
------------

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- oversampling 8N1 UART receiver.
//
// The serial line is resynchronised, the start bit is confirmed at its
// middle, then each data bit and the stop bit are sampled at their own
// middles using a tick-driven sub-bit counter.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-low reset
//   tick       : one-clk enable pulse at OVERSAMPLE x baud
//   rx         : asynchronous serial line, idle high, LSB first
//   data_out   : last correctly framed byte (held until the next good frame)
//   valid      : one-clk pulse, data_out has just been updated
//   frame_err  : one-clk pulse, stop bit was low and the byte was dropped
//   busy       : high while in START, DATA or STOP
//   dbg_state  : current FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//
// Handshake: valid and frame_err are single-cycle pulses with no
// backpressure; a consumer must capture data_out in the cycle valid is high
// or rely on data_out holding until the next good frame.
//
// OVERSAMPLE must be 8 or 16.
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_armed;
  logic [SW-1:0] r_sub_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;
  logic          r_busy;
  logic          w_rx_s;

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_armed   <= 1'b0;
      r_sub_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= 8'h00;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_sub_cnt <= '0;
          r_bit_cnt <= '0;
          // Arming on a seen '1' keeps a held-low line (break, or rx low
          // out of reset) from being mistaken for a stream of start bits.
          // The start edge is taken without waiting for tick so a start
          // that coincides with the STOP exit is not lost.
          if (w_rx_s) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (tick) begin
            if (r_sub_cnt == HALF_LAST) begin
              r_sub_cnt <= '0;
              if (!w_rx_s) begin
                r_state <= S_DATA;
              end else begin
                // Line went back high before mid-start: glitch, stay armed.
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_sub_cnt <= r_sub_cnt + SW'(1);
            end
          end
        end

        S_DATA: begin
          if (tick) begin
            // Wraps naturally at OVERSAMPLE-1, giving one sample per bit.
            r_sub_cnt <= r_sub_cnt + SW'(1);
            if (r_sub_cnt == FULL_LAST) begin
              r_shift[r_bit_cnt] <= w_rx_s;
              r_bit_cnt          <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_state   <= S_STOP;
                r_sub_cnt <= '0;
                r_bit_cnt <= '0;
              end
            end
          end
        end

        S_STOP: begin
          if (tick) begin
            if (r_sub_cnt == FULL_LAST) begin
              if (w_rx_s) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_ferr  <= 1'b1;
                r_armed <= 1'b0;
              end
              r_state   <= S_IDLE;
              r_busy    <= 1'b0;
              r_sub_cnt <= '0;
              r_bit_cnt <= '0;
            end else begin
              r_sub_cnt <= r_sub_cnt + SW'(1);
            end
          end
        end
      endcase
    end
  end

  assign data_out  = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx (OVERSAMPLE = 16).
//
// A bit-level line driver sends 8N1 frames timed in ticks. Each frame that
// should end in a pulse pushes {frame_err, expected data_out} onto exp_q and
// the tick count at its start edge onto start_q; a monitor pops on every
// valid/frame_err pulse and compares data, pulse kind, busy and the
// start-edge-to-pulse latency in ticks.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  // 0.5 start bit + 8 data bits + 1 stop bit, in ticks.
  localparam int LAT_TICKS = OS / 2 + 8 * OS + OS;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic [1:0] dbg_state;

  logic [8:0] exp_q[$];
  int         start_q[$];
  logic [7:0] last_data = 8'h00;
  bit         tick_en = 1'b1;
  int         tick_total = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / tick / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        tick = (div == 0);
        div  = (div + 1) % TICK_DIV;
      end else begin
        tick = 1'b0;
      end
    end
  end

  always @(posedge clk) if (tick) tick_total = tick_total + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (tick) k++;
    end
  endtask

  // Send one 8N1 frame. stall_bit >= 0 freezes tick for 50 clks partway
  // through that data bit. A bad stop bit leaves rx low on return.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input int stall_bit);
    logic [1:0] st;
    if (stop_ok) begin
      exp_q.push_back({1'b0, b});
      last_data = b;
    end else begin
      exp_q.push_back({1'b1, last_data});
    end
    @(negedge clk);
    start_q.push_back(tick_total);
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) check("busy_in_frame", {31'd0, busy}, 32'd1);
      rx = b[i];
      if (i == stall_bit) begin
        wait_ticks(5);
        @(negedge clk);
        tick_en = 1'b0;
        repeat (2) @(negedge clk);
        st = dbg_state;
        repeat (50) @(negedge clk);
        check("stall_state_hold", {30'd0, dbg_state}, {30'd0, st});
        check("stall_state_is_data", {30'd0, dbg_state}, 32'd2);
        tick_en = 1'b1;
        wait_ticks(OS - 5);
      end else begin
        wait_ticks(OS);
      end
    end
    @(negedge clk);
    rx = stop_ok;
    wait_ticks(OS);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    int         st;
    int         el;
    if (!rst) begin
      if (valid || frame_err) begin
        n_checks++;
        n_fail++;
        $display("FAIL pulse_in_reset: valid=%0b frame_err=%0b expected none",
                 valid, frame_err);
      end
    end else if (valid || frame_err) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b data_out=0x%0h expected no pulse",
                 valid, frame_err, data_out);
      end else begin
        e  = exp_q.pop_front();
        st = start_q.pop_front();
        el = tick_total - st;
        check("pulse_frame_err", {31'd0, frame_err}, {31'd0, e[8]});
        check("pulse_valid", {31'd0, valid}, {31'd0, ~e[8]});
        check("data_out", {24'd0, data_out}, {24'd0, e[7:0]});
        check("busy_at_pulse", {31'd0, busy}, 32'd0);
        n_checks++;
        if (el < LAT_TICKS || el > LAT_TICKS + 1) begin
          n_fail++;
          $display("FAIL latency_ticks: got %0d expected %0d..%0d",
                   el, LAT_TICKS, LAT_TICKS + 1);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    bit         ok;
    int         gap;

    // Reset state.
    rst = 1'b0;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b1;
    wait_ticks(OS);

    // Single good frame.
    send_frame(8'hA5, 1'b1, -1);
    wait_ticks(OS);

    // Start glitch: 4 ticks low then high.
    @(negedge clk);
    rx = 1'b0;
    wait_ticks(2);
    @(negedge clk);
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    wait_ticks(2);
    @(negedge clk);
    rx = 1'b1;
    wait_ticks(10);
    @(negedge clk);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    check("glitch_state_idle", {30'd0, dbg_state}, 32'd0);
    wait_ticks(OS);

    // Bad stop bit, then break held 3 more bit times.
    send_frame(8'h3C, 1'b0, -1);
    wait_ticks(3 * OS);
    @(negedge clk);
    check("break_busy_low", {31'd0, busy}, 32'd0);
    check("break_queue_drained", exp_q.size(), 32'd0);
    rx = 1'b1;
    wait_ticks(OS);

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    wait_ticks(OS);

    // Reset during bit 4 of 0x5A, then a normal frame.
    b = 8'h5A;
    @(negedge clk);
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx = b[i];
      wait_ticks(OS);
    end
    @(negedge clk);
    rx = b[4];
    wait_ticks(OS / 2);
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_data_out", {24'd0, data_out}, 32'd0);
    check("midrst_state", {30'd0, dbg_state}, 32'd0);
    last_data = 8'h00;
    rst = 1'b1;
    wait_ticks(OS);
    send_frame(8'hC3, 1'b1, -1);
    wait_ticks(OS);

    // Tick stall in the middle of DATA.
    send_frame(8'h96, 1'b1, 3);
    wait_ticks(OS);

    // Randomised frames.
    for (int n = 0; n < 20; n++) begin
      b   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 6) != 0);
      gap = ok ? $urandom_range(0, 2) : $urandom_range(1, 2);
      send_frame(b, ok, -1);
      if (!ok) begin
        @(negedge clk);
        rx = 1'b1;
      end
      wait_ticks(gap * OS + $urandom_range(0, 3));
    end

    wait_ticks(2 * OS);
    @(negedge clk);
    check("final_queue_empty", exp_q.size(), 32'd0);
    check("final_busy", {31'd0, busy}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
